mmio_ctrl: RTL and testbench

MMIO_CTRL -- requirements
Module: mmio_ctrl

---
 rtl/mmio_ctrl.sv | 62 ++++++
 tb/tb_mmio_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/mmio_ctrl.sv
// mmio_ctrl: memory-mapped output registers plus a compare/match timer with interrupt.
module mmio_ctrl #(
  parameter int MMIO_ADDR_START_BIT = 12,
  parameter int NUM_OUT_REGS = 4,
  parameter int OUT_WIDTH = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clk_enable,
  input  logic we,
  input  logic [3:0] be,
  input  logic [31:0] addr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic is_mmio,
  output logic [NUM_OUT_REGS*OUT_WIDTH-1:0] out_regs,
  output logic irq
);
  localparam int N = NUM_OUT_REGS;
  logic [NUM_OUT_REGS-1:0][OUT_WIDTH-1:0] outr;
  logic [31:0] idx, wmask, rdata, count, cmp;
  logic [2:0] ctrl;
  logic match, acc, wr, cw, set, clr, unused;
  function automatic logic [31:0] merge(input logic [31:0] old);
    return (old & ~wmask) | (data_in & wmask);
  endfunction
  assign is_mmio = addr[MMIO_ADDR_START_BIT];
  assign idx = 32'(addr[MMIO_ADDR_START_BIT-2:2]);
  assign unused = ^{addr[31:MMIO_ADDR_START_BIT+1], addr[MMIO_ADDR_START_BIT-1], addr[1:0]};
  assign wmask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  assign acc = clk_enable & is_mmio;
  assign wr = acc & we;
  assign cw = wr && idx == N;
  assign clr = wr && idx == N + 3 && be[0] && data_in[0];
  // a software COUNT write suppresses match evaluation on that edge
  assign set = ctrl[0] && !cw && count == cmp;
  assign out_regs = outr;
  assign irq = match & ctrl[2];
  always_comb begin
    rdata = idx == N ? count : idx == N + 1 ? cmp : idx == N + 2 ? {29'b0, ctrl} :
            idx == N + 3 ? {31'b0, match} : '0;
    for (int k = 0; k < N; k++) if (idx == k) rdata = 32'(outr[k]);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) outr <= '0;
    else if (wr)
      for (int k = 0; k < N; k++) if (idx == k) outr[k] <= OUT_WIDTH'(merge(32'(outr[k])));
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      data_out <= '0;
      count <= '0;
      cmp <= '0;
      ctrl <= '0;
      match <= 1'b0;
    end else if (clk_enable) begin
      if (acc) data_out <= rdata;
      if (wr && idx == N + 1) cmp <= merge(cmp);
      if (wr && idx == N + 2) ctrl <= 3'(merge({29'b0, ctrl}));
      count <= cw ? merge(count) : !ctrl[0] ? count : set && ctrl[1] ? '0 : count + 1;
      match <= set | (match & ~clr);
    end
endmodule

// File: tb/tb_mmio_ctrl.sv
// tb_mmio_ctrl: directed and random checks of mmio_ctrl against a behavioural model.
module tb_mmio_ctrl;
  localparam int MB = 12;
  localparam int N = 4;
  localparam int W = 16;
  localparam logic [31:0] OM = 32'((64'd1 << W) - 1);
  logic clk = 0, rst = 0, ce = 0, we = 0;
  logic [3:0] be = 0;
  logic [31:0] addr = 0, din = 0;
  logic [31:0] dout;
  logic is_mmio, irq;
  logic [N*W-1:0] oregs;
  int n_chk = 0, n_fail = 0;
  logic [31:0] out_m [N];
  logic [31:0] cnt_m, cmp_m, ctrl_m, dout_m, c0;
  logic match_m;

  mmio_ctrl #(.MMIO_ADDR_START_BIT(MB), .NUM_OUT_REGS(N), .OUT_WIDTH(W)) dut (
    .clk(clk), .rst(rst), .clk_enable(ce), .we(we), .be(be), .addr(addr),
    .data_in(din), .data_out(dout), .is_mmio(is_mmio), .out_regs(oregs), .irq(irq));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic mreset();
    for (int k = 0; k < N; k++) out_m[k] = 0;
    cnt_m = 0; cmp_m = 0; ctrl_m = 0; dout_m = 0; match_m = 0;
  endtask

  function automatic logic [31:0] rd_m(input int i);
    if (i < N) return out_m[i];
    if (i == N) return cnt_m;
    if (i == N + 1) return cmp_m;
    if (i == N + 2) return ctrl_m;
    if (i == N + 3) return {31'b0, match_m};
    return 0;
  endfunction

  function automatic logic [N*W-1:0] oregs_m();
    logic [N*W-1:0] v;
    for (int k = 0; k < N; k++) v[k*W +: W] = out_m[k][W-1:0];
    return v;
  endfunction

  // one rising edge of the abstract machine
  task automatic model_edge(input logic c, input logic w, input logic [3:0] b,
                            input logic [31:0] a, input logic [31:0] d);
    int i;
    logic [31:0] m, nxt;
    logic hit, wipe, swc, mm;
    if (!c) return;
    mm = a[MB];
    i = int'(a[MB-2:2]);
    m = {{8{b[3]}}, {8{b[2]}}, {8{b[1]}}, {8{b[0]}}};
    if (mm) dout_m = rd_m(i);
    swc = mm && w && i == N;
    wipe = mm && w && i == N + 3 && b[0] && d[0];
    hit = 0;
    nxt = cnt_m;
    if (swc) nxt = (cnt_m & ~m) | (d & m);
    else if (ctrl_m[0]) begin
      hit = cnt_m == cmp_m;
      nxt = (hit && ctrl_m[1]) ? 0 : cnt_m + 1;
    end
    match_m = hit || (match_m && !wipe);
    if (mm && w) begin
      if (i < N) out_m[i] = ((out_m[i] & ~m) | (d & m)) & OM;
      if (i == N + 1) cmp_m = (cmp_m & ~m) | (d & m);
      if (i == N + 2) ctrl_m = ((ctrl_m & ~m) | (d & m)) & 32'h7;
    end
    cnt_m = nxt;
  endtask

  task automatic check_all();
    chk("data_out", 64'(dout), 64'(dout_m));
    chk("out_regs", 64'(oregs), 64'(oregs_m()));
    chk("irq", 64'(irq), 64'(match_m & ctrl_m[2]));
  endtask

  task automatic step(input logic c, input logic w, input logic [3:0] b,
                      input logic [31:0] a, input logic [31:0] d);
    ce = c; we = w; be = b; addr = a; din = d;
    #1 chk("is_mmio", 64'(is_mmio), 64'(a[MB]));
    @(posedge clk);
    model_edge(c, w, b, a, d);
    #1 check_all();
  endtask

  function automatic logic [31:0] ad(input int i);
    return 32'(1 << MB) | 32'(i << 2);
  endfunction

  task automatic wr(input int i, input logic [3:0] b, input logic [31:0] d);
    step(1, 1, b, ad(i), d);
  endtask

  task automatic rd(input int i);
    step(1, 0, 4'h0, ad(i), 0);
  endtask

  task automatic idle();
    step(1, 0, 4'h0, 0, 0);
  endtask

  initial begin
    mreset();
    #1 rst = 1;
    #1 check_all();
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 0;
    idle();
    // output register write then read back
    wr(0, 4'b0011, 32'h1234);
    rd(0);
    chk("out0_read", 64'(dout), 64'h1234);
    chk("out0_drive", 64'(oregs[15:0]), 64'h1234);
    // partial byte write, unmapped index
    wr(1, 4'b0011, 32'hABCD);
    wr(1, 4'b0001, 32'hFFFF);
    rd(1);
    chk("out1_bytewr", 64'(dout), 64'hABFF);
    wr(N + 5, 4'hF, 32'hDEADBEEF);
    rd(N + 5);
    chk("unmapped_rd", 64'(dout), 64'h0);
    // auto-reload period of 6 with interrupt
    wr(N + 2, 4'hF, 0);
    wr(N + 1, 4'hF, 5);
    wr(N, 4'hF, 0);
    wr(N + 2, 4'hF, 7);
    repeat (5) idle();
    chk("irq_before", 64'(irq), 64'h0);
    idle();
    chk("irq_match", 64'(irq), 64'h1);
    rd(N);
    chk("count_reload", 64'(dout), 64'h0);
    wr(N + 3, 4'h1, 1);
    chk("w1c_clear", 64'(irq), 64'h0);
    repeat (3) idle();
    wr(N + 3, 4'h1, 1);
    chk("w1c_vs_set", 64'(irq), 64'h1);
    wr(N + 3, 4'h1, 1);
    chk("w1c_after", 64'(irq), 64'h0);
    // free-running wrap through 0xFFFFFFFF
    wr(N + 2, 4'hF, 0);
    wr(N + 3, 4'h1, 1);
    wr(N + 1, 4'hF, 3);
    wr(N, 4'hF, 32'hFFFFFFFE);
    wr(N + 2, 4'hF, 1);
    rd(N);
    chk("wrap_fe", 64'(dout), 64'hFFFFFFFE);
    rd(N);
    chk("wrap_ff", 64'(dout), 64'hFFFFFFFF);
    rd(N);
    chk("wrap_0", 64'(dout), 64'h0);
    rd(N);
    chk("wrap_1", 64'(dout), 64'h1);
    rd(N + 3);
    chk("nomatch_2", 64'(dout), 64'h0);
    rd(N + 3);
    chk("nomatch_3", 64'(dout), 64'h0);
    rd(N + 3);
    chk("match_3", 64'(dout), 64'h1);
    // asynchronous reset with a write held on the bus
    wr(N + 2, 4'hF, 7);
    ce = 1; we = 1; be = 4'hF; addr = ad(0); din = 32'hFFFF;
    @(negedge clk);
    #1 rst = 1;
    #1;
    mreset();
    chk("rst_dout", 64'(dout), 64'h0);
    chk("rst_oregs", 64'(oregs), 64'h0);
    chk("rst_irq", 64'(irq), 64'h0);
    @(posedge clk);
    @(negedge clk);
    ce = 0; we = 0; addr = 0;
    rst = 0;
    idle();
    // stall freezes everything
    wr(N + 2, 4'hF, 1);
    repeat (4) idle();
    c0 = cnt_m;
    repeat (3) step(0, 1, 4'hF, ad(N), 32'h5555);
    ce = 1; we = 0; addr = ad(N);
    @(posedge clk);
    model_edge(1, 0, 4'h0, ad(N), 0);
    #1 chk("freeze_count", 64'(dout), 64'(c0));
    check_all();
    // random traffic
    for (int t = 0; t < 400; t++) begin
      int i;
      logic [31:0] a, d;
      i = int'($urandom_range(0, N + 5));
      a = ($urandom_range(0, 7) != 0) ? ad(i) : 32'(i << 2);
      d = (i == N || i == N + 1) ? 32'($urandom_range(0, 15)) : $urandom;
      step($urandom_range(0, 7) != 0, 1'($urandom), 4'($urandom), a, d);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
